mem_copy_engine: RTL
====================

Name: mem_copy_engine

Overview:
- Bus-initiator DMA block that drives the dual-port block RAM.
- Copies a contiguous run of 32-bit words from a source address to a destination address in the same memory.
- Reads are issued on port a; writes are issued on port b.
- Throughput is one word per cycle, using the RAM's 1-cycle registered read latency. Control comes from a single start/done handshake.

Parameters:
ADDR_WIDTH, 16, word-address width; must match the attached memory; addresses wrap modulo 2^ADDR_WIDTH
LEN_WIDTH, ADDR_WIDTH+1, length width; allows copying the whole memory (2^ADDR_WIDTH words)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  1-cycle request; sampled only in IDLE
src  in  ADDR_WIDTH  source base address, captured on accepted start
dst  in  ADDR_WIDTH  destination base address, captured on accepted start
len  in  LEN_WIDTH  word count, captured on accepted start
abort  in  1  stop issuing reads; sampled in RUN only
busy  out  1  high from the cycle after an accepted start until the cycle before done
done  out  1  1-cycle completion pulse
aborted  out  1  valid with done; 1 if the transfer ended by abort
words  out  LEN_WIDTH  count of words written; holds until next accepted start
mem_ena  out  1  port a enable (read)
mem_wea  out  1  port a write enable; constant 0
mem_addra  out  ADDR_WIDTH  port a address
mem_dia  out  32  constant 0
mem_doa  in  32  port a read data (valid the cycle after mem_ena)
mem_enb  out  1  port b enable (write)
mem_web  out  1  port b write enable
mem_addrb  out  ADDR_WIDTH  port b address
mem_dib  out  32  port b write data; equals mem_doa combinationally

Behaviour:
- Reset (async, any state) forces: state=IDLE; busy, done, aborted, words, mem_ena, mem_enb and mem_web = 0; addresses = 0. An in-flight transfer is dropped and no further memory accesses occur.
- States:
  - IDLE → RUN on start with len≠0.
  - IDLE → DONE on start with len=0; no memory access, done pulses the next cycle, words=0.
  - RUN → DRAIN after the last read, or on abort.
  - DRAIN → DONE (one cycle).
  - DONE → IDLE (one cycle, done=1).
- Accepted start at edge E0 gives the following cycle timing:
  - Reads: cycles 1..N, mem_ena=1, mem_addra=src+k.
  - Writes: cycles 2..N+1, mem_enb=mem_web=1, mem_addrb=dst+k, mem_dib=mem_doa.
  - busy: cycles 1..N+1.
  - done: cycle N+2.
- Exactly one write follows every issued read, one cycle later, including the read issued in the abort cycle.
- Abort asserted in RUN cycle j (read j already issued in that cycle):
  - No read in cycle j+1; the DRAIN write completes.
  - done pulses with aborted=1 and words=j.
  - Abort outside RUN is ignored.
- start while busy/DRAIN/DONE is ignored; inputs are not re-captured.
- Addresses increment modulo 2^ADDR_WIDTH; wrap is silent.
- len=2^ADDR_WIDTH copies the entire memory.
- Overlapping regions copy in ascending order. Each word is read one cycle before its write; read-after-write at the same address is governed by the memory, and the engine does not detect overlap.
- words increments on each write and clears on accepted start.

Optional Feature:
- Macro: MEM_COPY_CHECKSUM_EN.
- Defined:
  - Adds output checksum [31:0], the mod-2^32 sum of all words written in the current transfer.
  - Cleared on accepted start and on reset; final value valid with done and held until the next start.
- Undefined: no checksum port and no adder logic.

Test Plan:
- Preload mem[0x10..0x13]=A,B,C,D; start src=0x10 dst=0x40 len=4 → reads in cycles 1-4, writes in cycles 2-5, done in cycle 6, mem[0x40..0x43]=A,B,C,D, words=4, aborted=0.
- start len=0 → done next cycle, mem_ena and mem_enb never high, words=0.
- src=0xFFFE dst=0x0100 len=4 (ADDR_WIDTH=16) → reads 0xFFFE, 0xFFFF, 0x0000, 0x0001; mem[0x100..0x103] match.
- len=8, abort in the cycle of the 3rd read → exactly 3 writes, done with aborted=1, words=3, mem[dst+3] unchanged.
- Assert rst asynchronously mid-RUN (len=16, after 5 reads) → all outputs 0 immediately, no further enables; a new start works normally. Also: start pulsed while busy is ignored.
- MEM_COPY_CHECKSUM_EN: copy 1, 2, 0xFFFFFFFF → checksum=0x00000002 at done.

Source files
------------

// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
//
// Bus-initiator copy engine for a dual-port block RAM with a 1-cycle
// registered read. It copies a contiguous run of 32-bit words from a source
// address to a destination address in the same memory, at one word per cycle.
// Reads go out on port a. Writes go out on port b one cycle after each read,
// so the write data is simply the port-a read data passed straight through.
//
// Optional feature (compile-time macro MEM_COPY_CHECKSUM_EN):
//   When defined, adds output checksum[31:0]. It holds the mod-2^32 sum of
//   every word written in the current transfer.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   start           1-cycle request, only looked at in IDLE
//   src, dst, len   base addresses and word count, captured on accepted start
//   abort           stop issuing reads, only looked at in RUN
//   busy            high from the cycle after an accepted start up to the
//                   cycle before done
//   done, aborted   1-cycle completion pulse, plus the abort flag valid with it
//   words           number of words written, held until the next start
//   mem_*a          port a (read only: wea and dia tied to 0)
//   mem_*b          port b (write); mem_dib = mem_doa
//   checksum        (MEM_COPY_CHECKSUM_EN only) running sum of written words
//
// Handshake: a start pulse seen while in IDLE is accepted at that clock edge.
// src, dst and len are captured at the same edge. Any further start is
// ignored until the engine is back in IDLE. The transfer always finishes with
// exactly one done pulse. That pulse arrives the cycle after the last write,
// or the cycle after acceptance when len is 0.
// -----------------------------------------------------------------------------
module mem_copy_engine #(
   parameter int ADDR_WIDTH = 16,
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src,
   input  logic [ADDR_WIDTH-1:0] dst,
   input  logic [LEN_WIDTH-1:0]  len,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic [LEN_WIDTH-1:0]  words,
   output logic                  mem_ena,
   output logic                  mem_wea,
   output logic [ADDR_WIDTH-1:0] mem_addra,
   output logic [31:0]           mem_dia,
   input  logic [31:0]           mem_doa,
   output logic                  mem_enb,
   output logic                  mem_web,
   output logic [ADDR_WIDTH-1:0] mem_addrb,
   output logic [31:0]           mem_dib
`ifdef MEM_COPY_CHECKSUM_EN
   ,
   output logic [31:0]           checksum
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                state_q,   state_d;
   logic                  busy_q,    busy_d;
   logic                  done_q,    done_d;
   logic                  aborted_q, aborted_d;
   logic [LEN_WIDTH-1:0]  words_q,   words_d;
   logic [LEN_WIDTH-1:0]  len_q,     len_d;
   logic [LEN_WIDTH-1:0]  rd_cnt_q,  rd_cnt_d;   // reads issued so far
   logic                  ena_q,     ena_d;
   logic [ADDR_WIDTH-1:0] addra_q,   addra_d;    // doubles as the read pointer
   logic                  enb_q,     enb_d;
   logic                  web_q,     web_d;
   logic [ADDR_WIDTH-1:0] addrb_q,   addrb_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q,  wr_ptr_d;   // next destination address
`ifdef MEM_COPY_CHECKSUM_EN
   logic [31:0]           sum_q,     sum_d;
`endif

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      aborted_d = aborted_q;
      words_d   = words_q;
      len_d     = len_q;
      rd_cnt_d  = rd_cnt_q;
      ena_d     = 1'b0;
      addra_d   = addra_q;
      enb_d     = 1'b0;
      web_d     = 1'b0;
      addrb_d   = addrb_q;
      wr_ptr_d  = wr_ptr_q;
`ifdef MEM_COPY_CHECKSUM_EN
      sum_d     = sum_q;
`endif

      // Every read issued this cycle becomes a write next cycle. This holds
      // regardless of state, so the read issued in the abort cycle (or the
      // last read) is still written back while the engine is in DRAIN.
      if (ena_q) begin
         enb_d    = 1'b1;
         web_d    = 1'b1;
         addrb_d  = wr_ptr_q;
         wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end

      // A write is in progress this cycle, and mem_doa carries its data.
      if (enb_q) begin
         words_d = words_q + LEN_WIDTH'(1);
`ifdef MEM_COPY_CHECKSUM_EN
         sum_d   = sum_q + mem_doa;
`endif
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               words_d   = '0;
               aborted_d = 1'b0;
               len_d     = len;
               wr_ptr_d  = dst;
`ifdef MEM_COPY_CHECKSUM_EN
               sum_d     = '0;
`endif
               if (len != '0) begin
                  state_d  = S_RUN;
                  busy_d   = 1'b1;
                  ena_d    = 1'b1;
                  addra_d  = src;
                  rd_cnt_d = LEN_WIDTH'(1);
               end else begin
                  // An empty copy skips straight to completion.
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end
         end

         S_RUN: begin
            if ((rd_cnt_q == len_q) || abort) begin
               state_d   = S_DRAIN;
               aborted_d = abort;
            end else begin
               ena_d    = 1'b1;
               addra_d  = addra_q + ADDR_WIDTH'(1);
               rd_cnt_d = rd_cnt_q + LEN_WIDTH'(1);
            end
         end

         S_DRAIN: begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         words_q   <= '0;
         len_q     <= '0;
         rd_cnt_q  <= '0;
         ena_q     <= 1'b0;
         addra_q   <= '0;
         enb_q     <= 1'b0;
         web_q     <= 1'b0;
         addrb_q   <= '0;
         wr_ptr_q  <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
         sum_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         words_q   <= words_d;
         len_q     <= len_d;
         rd_cnt_q  <= rd_cnt_d;
         ena_q     <= ena_d;
         addra_q   <= addra_d;
         enb_q     <= enb_d;
         web_q     <= web_d;
         addrb_q   <= addrb_d;
         wr_ptr_q  <= wr_ptr_d;
`ifdef MEM_COPY_CHECKSUM_EN
         sum_q     <= sum_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign aborted   = aborted_q;
   assign words     = words_q;
   assign mem_ena   = ena_q;
   assign mem_wea   = 1'b0;
   assign mem_addra = addra_q;
   assign mem_dia   = 32'd0;
   assign mem_enb   = enb_q;
   assign mem_web   = web_q;
   assign mem_addrb = addrb_q;
   assign mem_dib   = mem_doa;
`ifdef MEM_COPY_CHECKSUM_EN
   assign checksum  = sum_q;
`endif

endmodule
